sdrd_deserializer: RTL and testbench
====================================

# sdrd_deserializer

Serial-to-parallel capture stage that consumes the SDRD serial bit stream produced by the bus-side sequencer PAL and presents completed bytes to the host bus as a readable data register with status flags. It sits directly downstream of the sequencer. It qualifies each SDRD bit with a one-cycle strobe, assembles bytes MSB first, and double-buffers them. It also reports overrun and stalled-frame (timeout) conditions.

## Interface
Parameters:
- TIMEOUT, 255: idle clock cycles allowed between strobes inside a byte before the partial byte is aborted; legal range 1..65535.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- sdrd  in  1  serial data bit from the sequencer.
- bit_stb  in  1  one-cycle qualifier; sdrd is sampled on a rising edge where bit_stb=1.
- frame_sync  in  1  one-cycle pulse marking the start of a new byte; discards any partial byte.
- rd_stb  in  1  one-cycle host read of the data register; clears data_ready.
- clr_err  in  1  one-cycle pulse clearing all sticky error flags.
- data  out  8  last completed byte.
- data_ready  out  1  data holds an unread byte.
- busy  out  1  partial byte in progress (state SHIFT or PAR).
- overrun  out  1  sticky; a byte completed while data_ready=1 and no rd_stb was asserted in that cycle.
- timeout_err  out  1  sticky; a partial byte was aborted by timeout.
- parity_err  out  1  sticky; parity mismatch (see Configuration).

## Operation
- State machine states:
  - IDLE: no partial byte.
  - SHIFT: collecting bits 7..0.
  - PAR: awaiting the parity bit; this state exists only with the parity feature compiled in.
- Shift register `sr[7:0]` with a 3-bit counter `bitcnt`.
- Bit accepted (bit_stb=1, frame_sync=0):
  - sr <= {sr[6:0], sdrd}; bitcnt increments.
  - IDLE moves to SHIFT on the first accepted bit.
- 8th bit accepted:
  - Without parity: data <= {sr[6:0], sdrd}, data_ready <= 1, state returns to IDLE, bitcnt <= 0.
  - With parity: byte is held internally and state moves to PAR.
- Overrun: set when a byte completes while data_ready=1 and rd_stb=0. The old byte is overwritten by the new one.
- Simultaneous completion and rd_stb: the host has read the old byte that cycle. The new byte loads, data_ready stays 1, and overrun is not set.
- rd_stb with no byte completing: data_ready <= 0. data is unchanged.
- frame_sync:
  - Forces bitcnt <= 0 and discards the partial byte. No error flag is set.
  - If bit_stb is high in the same cycle, that bit is taken as bit 7 of the new byte and the state becomes SHIFT. Otherwise the state becomes IDLE.
- Timeout:
  - A 16-bit counter clears on every accepted bit and increments each cycle while in SHIFT or PAR.
  - When the counter reaches TIMEOUT: partial byte discarded, state to IDLE, timeout_err <= 1.
  - If bit_stb is asserted in the cycle the counter reaches TIMEOUT, the bit is accepted and no timeout occurs.
- clr_err clears overrun, timeout_err and parity_err. If a set condition coincides with clr_err, the set wins.
- Reset: state IDLE, sr=0, bitcnt=0, timeout counter=0, data=8'h00, and data_ready, busy, overrun, timeout_err, parity_err all 0.
- Reset mid-byte: the partial byte is discarded immediately.

## Timing
- All outputs are registered. data and data_ready update on the same edge that samples the final bit (or the parity bit), and are visible the following cycle.
- Minimum byte time: 8 consecutive bit_stb cycles, or 9 with parity. Back-to-back bytes are supported with no dead cycle.
- The host may assert rd_stb on any cycle. data is stable from the cycle data_ready rises until the next byte completes.
- busy rises the cycle after the first accepted bit and falls the cycle after completion, abort or frame_sync.

## Configuration
- Macro: SDRD_PARITY_EN.
- Defined:
  - A 9th strobed bit follows each byte as odd parity over the 8 data bits plus the parity bit.
  - On the parity bit: data loads and data_ready sets regardless of the check.
  - parity_err is set if the XOR of all 9 bits is 0.
- Undefined:
  - PAR state and parity logic are absent, and bytes complete on the 8th bit.
  - parity_err is tied to 0.

## Test plan
- Reset, then 8 strobes carrying bits 1,0,1,0,0,1,0,1 -> data=8'hA5, data_ready=1 one cycle after the 8th strobe, busy=0, all errors 0.
- Two bytes 8'h3C then 8'hC3 back-to-back, no rd_stb -> data=8'hC3, overrun=1. Repeat with rd_stb on the 2nd byte's final strobe cycle -> overrun=0, data_ready=1.
- TIMEOUT=4: 3 strobes, then idle 4 cycles -> timeout_err=1, busy=0. A following full byte 8'h81 yields data=8'h81.
- 5 bits, then frame_sync with bit_stb and sdrd=1, then 7 more bits 0000001 -> data=8'h81, no error flags.
- SDRD_PARITY_EN defined: byte 8'h01 with parity bit 0 -> data=8'h01, parity_err=0. With parity bit 1 -> parity_err=1. clr_err -> parity_err=0.
- Assert rst asynchronously mid-byte after 4 bits -> all outputs 0 immediately. The next 8 bits form a clean byte.

Source files
------------

// File: rtl/sdrd_deserializer.sv
// SDRD serial capture: strobed bits assembled MSB first into a host-readable data register.
// Optional odd-parity bit after each byte is enabled by defining SDRD_PARITY_EN.
module sdrd_deserializer #(
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sdrd,
   input  logic       bit_stb,
   input  logic       frame_sync,
   input  logic       rd_stb,
   input  logic       clr_err,
   output logic [7:0] data,
   output logic       data_ready,
   output logic       busy,
   output logic       overrun,
   output logic       timeout_err,
   output logic       parity_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   // Abort fires on the edge where the idle counter would reach TIMEOUT.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  shiftReg_q, shiftReg_d;
   logic [2:0]  bitCnt_q, bitCnt_d;
   logic [15:0] tmoCnt_q, tmoCnt_d;
   logic [7:0]  dataReg_q, dataReg_d;
   logic        dataReady_q, dataReady_d;
   logic        busy_q, busy_d;
   logic        overrun_q, overrun_d;
   logic        timeoutErr_q, timeoutErr_d;
   logic        byteDone;
   logic [7:0]  byteNew;
   logic        tmoSet;
   logic        ovrSet;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         shiftReg_q   <= 8'h00;
         bitCnt_q     <= 3'd0;
         tmoCnt_q     <= 16'd0;
         dataReg_q    <= 8'h00;
         dataReady_q  <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         timeoutErr_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shiftReg_q   <= shiftReg_d;
         bitCnt_q     <= bitCnt_d;
         tmoCnt_q     <= tmoCnt_d;
         dataReg_q    <= dataReg_d;
         dataReady_q  <= dataReady_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
         timeoutErr_q <= timeoutErr_d;
      end
   end

`ifdef SDRD_PARITY_EN
   logic parityErr_q, parityErr_d;
   logic parSet;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parityErr_q <= 1'b0;
      end else begin
         parityErr_q <= parityErr_d;
      end
   end

   always_comb begin
      parityErr_d = (parityErr_q & ~clr_err) | parSet;
   end

   assign parity_err = parityErr_q;
`else
   assign parity_err = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      shiftReg_d = shiftReg_q;
      bitCnt_d   = bitCnt_q;
      tmoCnt_d   = tmoCnt_q;
      byteDone   = 1'b0;
      byteNew    = shiftReg_q;
      tmoSet     = 1'b0;
`ifdef SDRD_PARITY_EN
      parSet     = 1'b0;
`endif
      if (frame_sync) begin
         // A strobe coinciding with frame_sync is the first bit of the new byte.
         tmoCnt_d = 16'd0;
         if (bit_stb) begin
            shiftReg_d = {7'd0, sdrd};
            bitCnt_d   = 3'd1;
            state_d    = SHIFT;
         end else begin
            shiftReg_d = 8'h00;
            bitCnt_d   = 3'd0;
            state_d    = IDLE;
         end
      end else if (bit_stb) begin
         tmoCnt_d = 16'd0;
         case (state_q)
            IDLE, SHIFT: begin
               shiftReg_d = {shiftReg_q[6:0], sdrd};
               bitCnt_d   = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) begin
`ifdef SDRD_PARITY_EN
                  state_d  = PAR;
`else
                  byteDone = 1'b1;
                  byteNew  = {shiftReg_q[6:0], sdrd};
                  state_d  = IDLE;
`endif
               end else begin
                  state_d = SHIFT;
               end
            end
`ifdef SDRD_PARITY_EN
            PAR: begin
               byteDone = 1'b1;
               byteNew  = shiftReg_q;
               parSet   = ~(^{shiftReg_q, sdrd});
               bitCnt_d = 3'd0;
               state_d  = IDLE;
            end
`endif
            default: begin
               state_d  = IDLE;
               bitCnt_d = 3'd0;
            end
         endcase
      end else if (state_q != IDLE) begin
         if (tmoCnt_q == TMO_LAST) begin
            state_d    = IDLE;
            shiftReg_d = 8'h00;
            bitCnt_d   = 3'd0;
            tmoCnt_d   = 16'd0;
            tmoSet     = 1'b1;
         end else begin
            tmoCnt_d = tmoCnt_q + 16'd1;
         end
      end else begin
         tmoCnt_d = 16'd0;
      end
   end

   // A read in the completion cycle consumes the old byte, so it never counts as overrun.
   always_comb begin
      dataReg_d   = dataReg_q;
      dataReady_d = dataReady_q;
      ovrSet      = 1'b0;
      if (byteDone) begin
         dataReg_d   = byteNew;
         dataReady_d = 1'b1;
         ovrSet      = dataReady_q & ~rd_stb;
      end else if (rd_stb) begin
         dataReady_d = 1'b0;
      end
      busy_d       = (state_d != IDLE);
      overrun_d    = (overrun_q & ~clr_err) | ovrSet;
      timeoutErr_d = (timeoutErr_q & ~clr_err) | tmoSet;
   end

   assign data        = dataReg_q;
   assign data_ready  = dataReady_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;
   assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_sdrd_deserializer.sv
// Scoreboard bench for sdrd_deserializer with TIMEOUT=4; honours SDRD_PARITY_EN when defined.
module tb_sdrd_deserializer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sdrd = 1'b0;
   logic       bitStb = 1'b0;
   logic       frameSync = 1'b0;
   logic       rdStb = 1'b0;
   logic       clrErr = 1'b0;
   logic [7:0] data;
   logic       dataReady;
   logic       busy;
   logic       overrun;
   logic       timeoutErr;
   logic       parityErr;

   int compared = 0;
   int mismatched = 0;
   int cycleCnt = 0;

   typedef struct {
      int         due;
      logic [7:0] value;
   } exp_t;

   exp_t sbQ[$];

   sdrd_deserializer #(.TIMEOUT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .sdrd        (sdrd),
      .bit_stb     (bitStb),
      .frame_sync  (frameSync),
      .rd_stb      (rdStb),
      .clr_err     (clrErr),
      .data        (data),
      .data_ready  (dataReady),
      .busy        (busy),
      .overrun     (overrun),
      .timeout_err (timeoutErr),
      .parity_err  (parityErr)
   );

   // 10-unit clock; inputs change 1 unit after each rising edge.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt++;

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Expected bytes are retired on the falling edge of the cycle they should appear.
   always @(negedge clk) begin
      if (sbQ.size() > 0) begin
         if (sbQ[0].due == cycleCnt) begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("sbData", {8'd0, data}, {8'd0, e.value});
            checkOutput("sbReady", {15'd0, dataReady}, 16'd1);
         end else if (sbQ[0].due < cycleCnt) begin
            checkOutput("sbLate", cycleCnt[15:0], sbQ[0].due[15:0]);
            void'(sbQ.pop_front());
         end
      end
   end

   task automatic applyStimulus(input logic b, input logic s, input logic f, input logic r, input logic c);
      bitStb    = b;
      sdrd      = s;
      frameSync = f;
      rdStb     = r;
      clrErr    = c;
      @(posedge clk);
      #1;
      bitStb    = 1'b0;
      sdrd      = 1'b0;
      frameSync = 1'b0;
      rdStb     = 1'b0;
      clrErr    = 1'b0;
   endtask

   task automatic pushExpect(input logic [7:0] b);
      exp_t e;
      e.due   = cycleCnt + 1;
      e.value = b;
      sbQ.push_back(e);
   endtask

   // Sends the low nbits of b MSB first, plus the odd-parity bit when enabled.
   task automatic sendTail(input logic [7:0] b, input int nbits, input logic rd, input logic clr);
      for (int i = nbits - 1; i >= 0; i--) begin
`ifdef SDRD_PARITY_EN
         applyStimulus(1'b1, b[i], 1'b0, 1'b0, 1'b0);
`else
         if (i == 0) begin
            pushExpect(b);
            applyStimulus(1'b1, b[i], 1'b0, rd, clr);
         end else begin
            applyStimulus(1'b1, b[i], 1'b0, 1'b0, 1'b0);
         end
`endif
      end
`ifdef SDRD_PARITY_EN
      pushExpect(b);
      applyStimulus(1'b1, ~(^b), 1'b0, rd, clr);
`endif
   endtask

   task automatic sendByte(input logic [7:0] b, input logic rd, input logic clr);
      sendTail(b, 8, rd, clr);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic readData();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "Data"}, {8'd0, data}, 16'd0);
      checkOutput({tag, "Ready"}, {15'd0, dataReady}, 16'd0);
      checkOutput({tag, "Busy"}, {15'd0, busy}, 16'd0);
      checkOutput({tag, "Ovr"}, {15'd0, overrun}, 16'd0);
      checkOutput({tag, "Tmo"}, {15'd0, timeoutErr}, 16'd0);
      checkOutput({tag, "Par"}, {15'd0, parityErr}, 16'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("rst");
      rst = 1'b0;
      @(posedge clk);
      #1;

      sendByte(8'hA5, 1'b0, 1'b0);
      checkOutput("a5Busy", {15'd0, busy}, 16'd0);
      checkOutput("a5Ready", {15'd0, dataReady}, 16'd1);
      checkOutput("a5Ovr", {15'd0, overrun}, 16'd0);
      checkOutput("a5Tmo", {15'd0, timeoutErr}, 16'd0);
      checkOutput("a5Par", {15'd0, parityErr}, 16'd0);
      readData();
      checkOutput("rdReady", {15'd0, dataReady}, 16'd0);
      checkOutput("rdData", {8'd0, data}, 16'h00A5);

      sendByte(8'h3C, 1'b0, 1'b0);
      sendByte(8'hC3, 1'b0, 1'b0);
      checkOutput("ovrSet", {15'd0, overrun}, 16'd1);
      checkOutput("ovrData", {8'd0, data}, 16'h00C3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("ovrClr", {15'd0, overrun}, 16'd0);
      readData();
      sendByte(8'h3C, 1'b0, 1'b0);
      sendByte(8'hC3, 1'b1, 1'b0);
      checkOutput("rdLastOvr", {15'd0, overrun}, 16'd0);
      checkOutput("rdLastReady", {15'd0, dataReady}, 16'd1);
      sendByte(8'h5A, 1'b0, 1'b1);
      checkOutput("setWinsOvr", {15'd0, overrun}, 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      readData();
      checkOutput("clrRdOvr", {15'd0, overrun}, 16'd0);

      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("firstBusy", {15'd0, busy}, 16'd1);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      checkOutput("tmo3Err", {15'd0, timeoutErr}, 16'd0);
      checkOutput("tmo3Busy", {15'd0, busy}, 16'd1);
      idle(1);
      checkOutput("tmo4Err", {15'd0, timeoutErr}, 16'd1);
      checkOutput("tmo4Busy", {15'd0, busy}, 16'd0);
      checkOutput("tmo4Ready", {15'd0, dataReady}, 16'd0);
      sendByte(8'h81, 1'b0, 1'b0);
      checkOutput("tmoSticky", {15'd0, timeoutErr}, 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("tmoClr", {15'd0, timeoutErr}, 16'd0);

      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3);
      sendTail(8'hE7, 5, 1'b0, 1'b0);
      checkOutput("saveTmo", {15'd0, timeoutErr}, 16'd0);
      readData();

      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("fsBusy", {15'd0, busy}, 16'd1);
      sendTail(8'h81, 7, 1'b0, 1'b0);
      checkOutput("fsOvr", {15'd0, overrun}, 16'd0);
      checkOutput("fsTmo", {15'd0, timeoutErr}, 16'd0);
      checkOutput("fsPar", {15'd0, parityErr}, 16'd0);
      readData();
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("fsOnlyBusy", {15'd0, busy}, 16'd0);
      sendByte(8'h7E, 1'b0, 1'b0);
      checkOutput("fsOnlyTmo", {15'd0, timeoutErr}, 16'd0);

`ifdef SDRD_PARITY_EN
      readData();
      for (int i = 7; i >= 0; i--) applyStimulus(1'b1, i == 0, 1'b0, 1'b0, 1'b0);
      pushExpect(8'h01);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("parOk", {15'd0, parityErr}, 16'd0);
      readData();
      for (int i = 7; i >= 0; i--) applyStimulus(1'b1, i == 0, 1'b0, 1'b0, 1'b0);
      pushExpect(8'h01);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("parBad", {15'd0, parityErr}, 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("parClr", {15'd0, parityErr}, 16'd0);
`else
      checkOutput("parTied", {15'd0, parityErr}, 16'd0);
`endif

      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("preRstBusy", {15'd0, busy}, 16'd1);
      checkOutput("preRstReady", {15'd0, dataReady}, 16'd1);
      #2;
      rst = 1'b1;
      #1;
      checkAllZero("midRst");
      rst = 1'b0;
      @(posedge clk);
      #1;
      sendByte(8'h96, 1'b0, 1'b0);
      checkOutput("postRstBusy", {15'd0, busy}, 16'd0);
      checkOutput("postRstOvr", {15'd0, overrun}, 16'd0);

      @(negedge clk);
      #1;
      checkOutput("sbEmpty", sbQ.size(), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
